fetch_unit: RTL and testbench

// - Instruction fetch stage of the RoXXon SIMD processor; sits between instruction memory and decode.
// - Holds the program counter and issues word-addressed read requests to instruction memory.
// - Buffers returned instructions in an N-entry prefetch queue and hands them to decode, tagged with their PC.
// - Redirects on branch/jump from the execute stage, discarding all wrong-path instructions.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 92 +++++++++
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, entry type and constants for the fetch stage.
package fetch_pkg;

    localparam int DEF_ADDR    = 8;
    localparam int DEF_INSTR_W = 32;

    // Driven to decode whenever the prefetch queue is empty.
    localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR-1:0]    pc;
    } fetch_entry_t;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush and occupancy count.
// Used both as the prefetch queue and as the in-flight request PC FIFO.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    parameter int CNT_W = count_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Qualify push/pop: a flush cancels both; a full FIFO takes a push only alongside a pop.
    always_comb begin
        do_push = push && !flush && (!full || pop);
        do_pop  = pop && !flush && !empty;
    end

    // Next pointers, occupancy and storage contents.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction-memory request issue, prefetch
// queue and branch redirect handling for the fetch stage.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              N        = 2,
    parameter int              ADDR     = DEF_ADDR,
    parameter int              INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               RSTN,
    output logic               imem_req_valid,
    output logic [ADDR-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR-1:0]    instr_pc
);

    localparam int CNT_W = count_w(N);
    localparam int SUM_W = CNT_W + 1;
    localparam int ENT_W = INSTR_W + ADDR;

    logic [ADDR-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               started_q, started_d;

    logic               credit_ok;
    logic               req_valid;
    logic               req_fire;
    logic               rsp_keep;
    logic               q_pop;

    logic [ENT_W-1:0]   q_push_data;
    logic [ENT_W-1:0]   q_head;
    logic               q_empty;
    logic               q_full;
    logic [CNT_W-1:0]   q_count;
    logic [INSTR_W-1:0] head_instr;
    logic [ADDR-1:0]    head_pc;

    logic [ADDR-1:0]    pcf_head;
    logic               pcf_empty;
    logic               pcf_full;
    logic [CNT_W-1:0]   pcf_count;
    logic               unused_pcf;

    // Issue and response qualification. Queued plus in-flight fetches never
    // exceed N, which is what keeps the prefetch queue from overflowing.
    always_comb begin
        credit_ok = ({1'b0, q_count} + {1'b0, inflight_q}) < SUM_W'(N);
        req_valid = started_q && !redirect_valid && credit_ok;
        req_fire  = req_valid && imem_req_ready;
        rsp_keep  = imem_rsp_valid && !redirect_valid && (drop_q == '0);
    end

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_q;

    // PC advance/redirect, in-flight tracking and wrong-path drop count.
    always_comb begin
        started_d  = 1'b1;
        pc_d       = pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (req_fire) begin
            pc_d = pc_q + 1'b1;
        end

        if (req_fire && !imem_rsp_valid) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!req_fire && imem_rsp_valid) begin
            inflight_d = inflight_q - 1'b1;
        end

        // Every fetch still outstanding at a redirect is wrong-path; one
        // returning in the redirect cycle itself is discarded right away.
        if (redirect_valid) begin
            drop_d = imem_rsp_valid ? inflight_q - 1'b1 : inflight_q;
        end else if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
    end

    // Control registers; started_q holds issue off for the first cycle after reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            started_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            started_q  <= started_d;
        end
    end

    // Addresses of accepted requests, consumed in order as responses return.
    fetch_fifo #(
        .DEPTH (N),
        .WIDTH (ADDR),
        .CNT_W (CNT_W)
    ) u_pc_fifo (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (rsp_keep),
        .head_data (pcf_head),
        .empty     (pcf_empty),
        .full      (pcf_full),
        .count     (pcf_count)
    );

    assign q_push_data = {imem_rsp_data, pcf_head};

    // Prefetch queue of {instruction, pc} handed to decode.
    fetch_fifo #(
        .DEPTH (N),
        .WIDTH (ENT_W),
        .CNT_W (CNT_W)
    ) u_prefetch_q (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head_data (q_head),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

    assign {head_instr, head_pc} = q_head;

    // Decode-side outputs: NOP and PC 0 whenever the queue is empty.
    always_comb begin
        instr_valid = !q_empty;
        q_pop       = !q_empty && instr_ready;
        instr       = q_empty ? INSTR_W'(NOP_INSTR) : head_instr;
        instr_pc    = q_empty ? '0 : head_pc;
    end

    // The PC FIFO occupancy mirrors inflight minus drop; only its head is needed.
    assign unused_pcf = ^{pcf_count, pcf_empty, pcf_full, q_full};

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench with an in-order memory model and a
// sequential-PC reference for both request and decode streams.
module tb_fetch_unit;

    localparam int N       = 2;
    localparam int ADDR    = 8;
    localparam int INSTR_W = 32;

    logic               CLK = 1'b0;
    logic               RSTN;
    logic               imem_req_valid;
    logic [ADDR-1:0]    imem_req_addr;
    logic               imem_req_ready;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               redirect_valid;
    logic [ADDR-1:0]    redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR-1:0]    instr_pc;

    fetch_unit #(
        .N        (N),
        .ADDR     (ADDR),
        .INSTR_W  (INSTR_W),
        .RESET_PC (8'h00)
    ) dut (
        .CLK            (CLK),
        .RSTN           (RSTN),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [ADDR-1:0] addr;
        int              due;
    } mem_req_t;

    mem_req_t        mem_q[$];
    int              cyc;
    int              mem_lat_min;
    int              mem_lat_max;
    logic [ADDR-1:0] exp_out;
    logic [ADDR-1:0] exp_req;
    int              n_tests;
    int              n_fail;
    int              n_pops;
    int              n_acc;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR-1:0] a);
        return 32'hA000_0000 + {24'h0, a};
    endfunction

    task automatic drive_mem();
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    // One clock: starts just after a negedge with inputs set, ends at the next negedge.
    task automatic cycle();
        logic            acc;
        logic            rsp;
        logic            pop;
        logic            redir;
        logic [ADDR-1:0] acc_addr;
        int              lat;
        #1;
        acc      = imem_req_valid && imem_req_ready;
        rsp      = imem_rsp_valid;
        pop      = instr_valid && instr_ready;
        redir    = redirect_valid;
        acc_addr = imem_req_addr;
        if (pop) begin
            n_tests++;
            if (instr_pc !== exp_out || instr !== mem_word(exp_out)) begin
                n_fail++;
                $display("FAIL decode_order: got pc=%02h instr=%08h, want pc=%02h instr=%08h",
                         instr_pc, instr, exp_out, mem_word(exp_out));
            end
            exp_out = exp_out + 1'b1;
            n_pops++;
        end
        if (redir) begin
            n_tests++;
            if (imem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL redirect_no_issue: imem_req_valid=%b, want 0", imem_req_valid);
            end
            exp_out = redirect_pc;
            exp_req = redirect_pc;
        end
        if (acc) begin
            n_tests++;
            if (acc_addr !== exp_req) begin
                n_fail++;
                $display("FAIL req_addr: got %02h, want %02h", acc_addr, exp_req);
            end
            n_tests++;
            if (mem_q.size() >= N) begin
                n_fail++;
                $display("FAIL credit: outstanding=%0d at accept, want < %0d", mem_q.size(), N);
            end
            exp_req = exp_req + 1'b1;
            n_acc++;
        end
        @(posedge CLK);
        cyc++;
        if (rsp && mem_q.size() > 0) void'(mem_q.pop_front());
        if (acc) begin
            lat = int'($urandom_range(mem_lat_max, mem_lat_min));
            mem_q.push_back('{addr: acc_addr, due: cyc + lat - 1});
        end
        @(negedge CLK);
        drive_mem();
    endtask

    task automatic run_until_pops(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (n_pops < target && k < budget) begin
            cycle();
            k++;
        end
        n_tests++;
        if (n_pops < target) begin
            n_fail++;
            $display("FAIL %s_timeout: pops=%0d, want %0d within %0d cycles", tag, n_pops, target, budget);
        end
    endtask

    task automatic clear_model();
        mem_q.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        exp_out = 8'h00;
        exp_req = 8'h00;
        n_pops  = 0;
        n_acc   = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTN           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b0;
        clear_model();
        @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        @(posedge CLK);
        #1;
        n_tests++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valids: instr_valid=%b imem_req_valid=%b, want 0 0", instr_valid, imem_req_valid);
        end
        n_tests++;
        if (instr !== 32'h0 || instr_pc !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: instr=%08h instr_pc=%02h, want 0 0", instr, instr_pc);
        end
        @(negedge CLK);
        RSTN = 1'b1;
        cycle();
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_first_req: valid=%b addr=%02h, want 1 00", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        mem_lat_min = 1; mem_lat_max = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        run_until_pops(12, 100, "streaming");
        n_tests++;
        if (n_acc < 12) begin
            n_fail++;
            $display("FAIL streaming_reqs: accepted=%0d, want >= 12", n_acc);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mem_lat_min = 1; mem_lat_max = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        repeat (10) cycle();
        n_tests++;
        if (n_acc != N) begin
            n_fail++;
            $display("FAIL bp_req_count: accepted=%0d, want %0d", n_acc, N);
        end
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 8'h00) begin
            n_fail++;
            $display("FAIL bp_stall: req_valid=%b instr_valid=%b instr_pc=%02h, want 0 1 00",
                     imem_req_valid, instr_valid, instr_pc);
        end
        instr_ready = 1'b1;
        run_until_pops(5, 60, "bp_release");
        n_tests++;
        if (n_acc <= N) begin
            n_fail++;
            $display("FAIL bp_resume: accepted=%0d, want > %0d", n_acc, N);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        mem_lat_min = 3; mem_lat_max = 3;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        cycle();
        cycle();
        n_tests++;
        if (n_acc != 2) begin
            n_fail++;
            $display("FAIL redir_setup: accepted=%0d, want 2", n_acc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        cycle();
        redirect_valid = 1'b0;
        #1;
        n_tests++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_flush: instr_valid=%b, want 0", instr_valid);
        end
        run_until_pops(3, 60, "redirect");
    endtask

    task automatic test_wrap();
        do_reset();
        mem_lat_min = 1; mem_lat_max = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFF;
        cycle();
        redirect_valid = 1'b0;
        run_until_pops(3, 40, "wrap");
        n_tests++;
        if (exp_out !== 8'h02) begin
            n_fail++;
            $display("FAIL wrap_end: next expected pc=%02h, want 02", exp_out);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mem_lat_min = 1; mem_lat_max = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        run_until_pops(3, 30, "pre_async");
        #2;
        RSTN = 1'b0;
        #1;
        n_tests++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: instr_valid=%b imem_req_valid=%b, want 0 0", instr_valid, imem_req_valid);
        end
        clear_model();
        @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        run_until_pops(4, 40, "post_async");
    endtask

    task automatic test_random();
        do_reset();
        mem_lat_min = 1; mem_lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            instr_ready    = ($urandom_range(2, 0) != 0);
            if ($urandom_range(19, 0) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 8'($urandom);
            end else begin
                redirect_valid = 1'b0;
            end
            cycle();
        end
        redirect_valid = 1'b0;
        n_tests++;
        if (n_pops < 50) begin
            n_fail++;
            $display("FAIL random_progress: pops=%0d, want >= 50", n_pops);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        mem_lat_min = 1;
        mem_lat_max = 1;
        RSTN           = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        clear_model();

        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
